// File: rtl/alu_logic_stage_pkg.sv
// alu_logic_stage_pkg: op encodings and skid-buffer states shared by the ALU logic stage
package alu_logic_stage_pkg;
    typedef enum logic [1:0] {OP_AND = 2'b00, OP_OR = 2'b01, OP_XOR = 2'b10, OP_NOR = 2'b11} op_e;
    typedef enum logic [1:0] {S_EMPTY = 2'b00, S_ONE = 2'b01, S_TWO = 2'b10} state_e;
endpackage

// File: rtl/logic_unit_32.sv
// logic_unit_32: combinational bitwise AND/OR/XOR/NOR of two operands
module logic_unit_32
    import alu_logic_stage_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [1:0]       op_i,
    input  logic [WIDTH-1:0] in0_i,
    input  logic [WIDTH-1:0] in1_i,
    output logic [WIDTH-1:0] result_o
);
    always_comb begin
        result_o = op_i == OP_AND ? in0_i & in1_i :
                   op_i == OP_OR  ? in0_i | in1_i :
                   op_i == OP_XOR ? in0_i ^ in1_i : ~(in0_i | in1_i);
    end
endmodule

// File: rtl/alu_logic_stage.sv
// alu_logic_stage: registered bitwise logic stage behind a 2-entry skid buffer
module alu_logic_stage
    import alu_logic_stage_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] in0,
    input  logic [WIDTH-1:0] in1,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out,
    output logic             zero
);
    state_e           state_q, state_d;
    logic [WIDTH-1:0] main_q, main_d, skid_q, skid_d, res;
    logic             main_z_q, main_z_d, skid_z_q, skid_z_d, in_ready_q;
    logic             accept, xfer, take_new, take_skid, to_skid;

    logic_unit_32 #(.WIDTH(WIDTH)) u_lu (
        .op_i    (op),
        .in0_i   (in0),
        .in1_i   (in1),
        .result_o(res)
    );

    assign in_ready  = in_ready_q;
    assign out_valid = state_q != S_EMPTY;
    assign out       = main_q;
    assign zero      = main_z_q;

    always_comb begin
        accept    = in_valid && in_ready_q;
        xfer      = out_valid && out_ready;
        take_skid = state_q == S_TWO && xfer;
        take_new  = accept && (state_q == S_EMPTY || xfer);
        to_skid   = state_q == S_ONE && accept && !xfer;
        state_d   = state_q == S_EMPTY ? (accept ? S_ONE : S_EMPTY) :
                    state_q == S_ONE   ? (to_skid ? S_TWO : (xfer && !accept) ? S_EMPTY : S_ONE) :
                    (xfer ? S_ONE : S_TWO);
        main_d    = take_skid ? skid_q : take_new ? res : main_q;
        main_z_d  = take_skid ? skid_z_q : take_new ? ~|res : main_z_q;
        skid_d    = to_skid ? res : skid_q;
        skid_z_d  = to_skid ? ~|res : skid_z_q;
    end

    // in_ready comes from the next state so it never depends combinationally on out_ready
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_EMPTY;
            main_q     <= '0;
            main_z_q   <= 1'b0;
            skid_q     <= '0;
            skid_z_q   <= 1'b0;
            in_ready_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            main_q     <= main_d;
            main_z_q   <= main_z_d;
            skid_q     <= skid_d;
            skid_z_q   <= skid_z_d;
            in_ready_q <= state_d != S_TWO;
        end
    end
endmodule

// File: doc/alu_logic_stage.md
ALU_LOGIC_STAGE -- requirements
Module: alu_logic_stage

Interface
REQ-001 Parameter: WIDTH, default 32, datapath width in bits.
REQ-002 Port: clk  input  1  rising-edge clock, sole clock domain.
REQ-003 Port: rst  input  1  synchronous, active-high reset.
REQ-004 Port: in_valid  input  1  upstream operand set valid.
REQ-005 Port: in_ready  output  1  stage can accept an operand set this cycle.
REQ-006 Port: op  input  2  operation select: 00 AND, 01 OR, 10 XOR, 11 NOR.
REQ-007 Port: in0  input  WIDTH  operand A.
REQ-008 Port: in1  input  WIDTH  operand B.
REQ-009 Port: out_valid  output  1  result valid to downstream.
REQ-010 Port: out_ready  input  1  downstream accepts result.
REQ-011 Port: out  output  WIDTH  registered result.
REQ-012 Port: zero  output  1  high when out is all zeros; qualified by out_valid.

Function
REQ-013 The stage SHALL accept an operand set when in_valid and in_ready are both high at a rising clk edge.
REQ-014 The stage SHALL compute op on in0/in1 bitwise and combinationally, then register the result; latency SHALL be 1 cycle from accept to out_valid when empty.
REQ-015 The stage SHALL transfer a result when out_valid and out_ready are both high at a rising edge.
REQ-016 Buffering SHALL be a 2-entry skid: main output register plus one skid register; state machine EMPTY, ONE, TWO.
REQ-017 EMPTY: accept -> ONE; otherwise stay EMPTY.
REQ-018 ONE: accept with no transfer -> TWO (new result into skid); transfer with no accept -> EMPTY; accept and transfer in the same cycle -> stay ONE, main register takes new result.
REQ-019 TWO: transfer -> ONE, skid contents move to main register; no accept is possible in TWO.
REQ-020 in_ready SHALL be a registered signal, high in EMPTY and ONE and low in TWO; no combinational path from out_ready to in_ready.
REQ-021 out_valid SHALL be high in ONE and TWO; out and zero SHALL stay stable while out_valid is high and out_ready is low.
REQ-022 Results SHALL leave in acceptance order; no result dropped or duplicated under any in_valid/out_ready pattern.
REQ-023 zero SHALL be derived from the result value stored alongside it (registered), not recomputed from live inputs.
REQ-024 When in_valid is low, op/in0/in1 SHALL be ignored.

Reset
REQ-025 While rst is high at a clk edge: state -> EMPTY, out_valid=0, in_ready=0, out=0, zero=0, skid register cleared.
REQ-026 in_ready SHALL go high on the first clk edge after rst deasserts.
REQ-027 Reset asserted mid-operation SHALL discard all buffered results; no transfer SHALL be reported in the reset cycle.

Structure
REQ-028 A shared package SHALL hold the op encodings (OP_AND, OP_OR, OP_XOR, OP_NOR) and the state enumeration.
REQ-029 The bitwise operation SHALL live in one combinational sub-module logic_unit_32 (op, in0, in1 -> result); alu_logic_stage holds only control and registers.

Verification
REQ-030 Reset release, in_valid with op=00, in0=0xFFFF0000, in1=0x0F0F0F0F, out_ready=1 -> next cycle out=0x0F0F0000, out_valid=1, zero=0.
REQ-031 op=11, in0=0xFFFFFFFF, in1=0x00000000 -> out=0x00000000, zero=1; op=10 with in0=in1=0xA5A5A5A5 -> out=0, zero=1.
REQ-032 out_ready=0, three back-to-back accepts (OR of 1|2, 4|8, 16|32) -> in_ready drops after second accept; third is held off; out holds 0x3 stable; releasing out_ready yields 0x3, 0xC, 0x30 in order.
REQ-033 Continuous in_valid=1 and out_ready=1 for 16 cycles of XOR with incrementing operands -> one result per cycle, state stays ONE, in_ready never drops.
REQ-034 rst asserted while in TWO -> next cycle out_valid=0, out=0, in_ready=0; previously buffered results never appear after reset.
REQ-035 Random in_valid/out_ready toggling, 10k transactions against a scoreboard -> zero mismatches, no loss, no duplication.
